misr_response_analyzer: RTL
===========================

MISR_RESPONSE_ANALYZER -- requirements
Module: misr_response_analyzer

Interface
REQ-001 Parameter WIDTH, default 8: response and signature width, legal range 2..32.
REQ-002 Parameter POLY, default 8'hB8: MISR feedback tap mask, WIDTH bits.
REQ-003 Parameter SEED, default 0: MISR value loaded on start, WIDTH bits.
REQ-004 Parameter CNT_W, default 8: pattern counter width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 clear_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  begin a compaction run; sampled only in IDLE and DONE.
REQ-008 abort  input  1  terminate the current run.
REQ-009 num_pat  input  CNT_W  number of responses to compact; sampled on accepted start.
REQ-010 golden  input  WIDTH  expected signature; sampled in CHECK.
REQ-011 resp_valid  input  1  resp holds a DUT response this cycle.
REQ-012 resp  input  WIDTH  DUT response word.
REQ-013 busy  output  1  high in RUN and CHECK.
REQ-014 done  output  1  high in DONE.
REQ-015 pass  output  1  signature matched golden; meaningful only while done=1.
REQ-016 signature  output  WIDTH  current MISR contents.

Function
REQ-017 FSM states: IDLE, RUN, CHECK, DONE.
REQ-018 IDLE/DONE with start=1: misr<=SEED, count<=0, pass<=0, latch num_pat, go to RUN; if num_pat=0, go directly to CHECK.
REQ-019 RUN with resp_valid=1: misr <= {misr[WIDTH-2:0], ^(misr & POLY)} ^ resp; count<=count+1.
REQ-020 RUN with resp_valid=0: misr and count hold.
REQ-021 RUN: the accepted response at count = num_pat-1 moves the FSM to CHECK on that same edge.
REQ-022 CHECK: pass <= (misr == golden); go to DONE on the next edge, which is one cycle after the last response.
REQ-023 DONE: hold signature and pass until start or abort.
REQ-024 resp_valid outside RUN is ignored, and misr is unchanged.
REQ-025 start in RUN or CHECK is ignored.
REQ-026 abort=1 in any state: go to IDLE and set pass<=0; misr holds; abort has priority over start and resp_valid.
REQ-027 count never wraps within a run; the maximum run length is 2^CNT_W-1.

Reset
REQ-028 clear_n=0 immediately forces state IDLE, misr=SEED, count=0, pass=0, busy=0, done=0, with no clock required.
REQ-029 Reset asserted mid-run discards the run; after release the block waits for start.

Configuration
REQ-030 Macro MISR_ANALYZER_ERRCNT_EN adds an input exp[WIDTH] and an output err_cnt[CNT_W].
REQ-031 With the macro defined, each accepted RUN response with resp != exp increments err_cnt; err_cnt saturates at all-ones, clears on start and reset, and holds in DONE.
REQ-032 With the macro undefined, neither port exists and the remaining behaviour is identical.

Structure
REQ-033 A shared package holds the state enum (IDLE, RUN, CHECK, DONE) and the default POLY/SEED constants.
REQ-034 The MISR register and its next-state function are one sub-module, misr_core (ports clk, clear_n, load, shift, din, q), instantiated once; the FSM and counter live in the top.

Verification
REQ-035 WIDTH=4, POLY=4'b1001, SEED=0, num_pat=2, responses 4'h1 then 4'h2, golden=4'h1 -> signature 4'h1, done=1 one cycle after the last response, pass=1.
REQ-036 Same stimulus with golden=4'h2 -> done=1, pass=0, signature 4'h1.
REQ-037 num_pat=0 with start, golden=SEED -> busy for one cycle (CHECK), then done=1, pass=1.
REQ-038 resp_valid gaps: 4'h1, idle cycle, idle cycle, 4'h2 -> same signature 4'h1; count increments only on valid cycles.
REQ-039 clear_n=0 pulsed between clock edges after the first response -> busy=0, done=0, signature=SEED immediately; a fresh start reproduces REQ-035.
REQ-040 With MISR_ANALYZER_ERRCNT_EN: exp=4'h1 for both responses of REQ-035 -> err_cnt=1; abort in RUN -> IDLE, pass=0, start ignored on that cycle.

Source files
------------

// File: rtl/misr_response_analyzer_pkg.sv
// Shared types and default constants for the MISR response analyzer.
package misr_response_analyzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] DEF_POLY = 32'h0000_00B8;
  localparam logic [31:0] DEF_SEED = 32'h0000_0000;

endpackage

// File: rtl/misr_response_analyzer_if.sv
// Control/response bundle of the MISR response analyzer.
// MISR_ANALYZER_ERRCNT_EN adds the expected-response input and error counter.
interface misr_response_analyzer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_pat;
  logic [WIDTH-1:0] golden;
  logic             resp_valid;
  logic [WIDTH-1:0] resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;
`ifdef MISR_ANALYZER_ERRCNT_EN
  logic [WIDTH-1:0] exp;
  logic [CNT_W-1:0] err_cnt;

  modport master (output start, abort, num_pat, golden, resp_valid, resp, exp,
                  input  busy, done, pass, signature, err_cnt);
  modport slave  (input  start, abort, num_pat, golden, resp_valid, resp, exp,
                  output busy, done, pass, signature, err_cnt);
`else
  modport master (output start, abort, num_pat, golden, resp_valid, resp,
                  input  busy, done, pass, signature);
  modport slave  (input  start, abort, num_pat, golden, resp_valid, resp,
                  output busy, done, pass, signature);
`endif
endinterface

// File: rtl/misr_response_analyzer_misr_core.sv
// MISR register: loads SEED, or shifts with POLY feedback and folds in din.
module misr_core #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)   r_q <= SEED;
    else if (load)  r_q <= SEED;
    else if (shift) r_q <= {r_q[WIDTH-2:0], ^(r_q & POLY)} ^ din;
  end

  assign q = r_q;

endmodule

// File: rtl/misr_response_analyzer.sv
// MISR response analyzer: compacts num_pat responses, compares to golden.
// Optional MISR_ANALYZER_ERRCNT_EN counts responses differing from exp.
module misr_response_analyzer
  import misr_response_analyzer_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
  parameter int               CNT_W = 8
) (
  input logic                       clk,
  input logic                       clear_n,
  misr_response_analyzer_if.slave   bus
);

  // state    | meaning
  // IDLE     | waiting for start
  // RUN      | compacting responses until num_pat accepted
  // CHECK    | comparing signature with golden
  // DONE     | result held until start or abort
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_num_pat;
  logic             r_pass;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_q;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            w_load      = 1'b1;
            w_state_nxt = (bus.num_pat == '0) ? ST_CHECK : ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.resp_valid) begin
            w_shift = 1'b1;
            if (r_count == r_num_pat - CNT_W'(1)) w_state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_num_pat <= '0;
      r_pass    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_count   <= '0;
        r_num_pat <= bus.num_pat;
      end else if (w_shift) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (bus.abort || w_load)       r_pass <= 1'b0;
      else if (r_state == ST_CHECK)  r_pass <= (w_q == bus.golden);
    end
  end

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr_core (
    .clk     (clk),
    .clear_n (clear_n),
    .load    (w_load),
    .shift   (w_shift),
    .din     (bus.resp),
    .q       (w_q)
  );

`ifdef MISR_ANALYZER_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  // Saturating count of accepted responses that differ from exp
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)
      r_err_cnt <= '0;
    else if (w_load)
      r_err_cnt <= '0;
    else if (w_shift && (bus.resp != bus.exp) && (r_err_cnt != '1))
      r_err_cnt <= r_err_cnt + CNT_W'(1);
  end

  assign bus.err_cnt = r_err_cnt;
`endif

  assign bus.busy      = (r_state == ST_RUN) || (r_state == ST_CHECK);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.pass      = r_pass;
  assign bus.signature = w_q;

endmodule
